// File: rtl/dts_pkg.sv
// Shared definitions for the DTS sample-shift controller: lane state encoding,
// default lane count and slip direction encoding.
package dts_pkg;

    localparam int N_LANES_DEF = 12;

    typedef logic [1:0] lane_state_t;
    localparam lane_state_t ST_IDLE  = 2'd0;
    localparam lane_state_t ST_PULSE = 2'd1;
    localparam lane_state_t ST_HOLD  = 2'd2;

    localparam int DIR_ADV = 1;
    localparam int DIR_DLY = -1;

endpackage

// File: rtl/dts_shift_lane.sv
// One deformatter lane: paced slip FSM with a single pending slot, saturating
// signed position and sticky limit/overrun flags.
module dts_shift_lane
    import dts_pkg::*;
#(
    parameter int POS_W = 6,
    parameter int GAP   = 16
) (
    input  logic                    user_clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    adv_edge,
    input  logic                    dly_edge,
    output logic                    adv_pulse,
    output logic                    dly_pulse,
    output logic signed [POS_W-1:0] pos,
    output logic                    at_limit,
    output logic                    overrun,
    output logic                    busy
);

    localparam int CNT_W   = (GAP > 2) ? $clog2(GAP) : 1;
    localparam int POS_MAX = 2**(POS_W-1) - 1;

    lane_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             dir_up;
    logic             pend_vld;
    logic             pend_up;

    logic new_req, new_up, req_vld, req_up, in_range;
    int   nxt;

    // Simultaneous advance and delay edges cancel each other.
    assign new_req = adv_edge ^ dly_edge;
    assign new_up  = adv_edge;

    always_comb begin
        req_vld  = new_req | pend_vld;
        req_up   = new_req ? new_up : pend_up;
        nxt      = int'(pos) + (req_up ? DIR_ADV : DIR_DLY);
        in_range = (nxt <= POS_MAX) && (nxt >= -POS_MAX);
    end

    always_ff @(posedge user_clk) begin
        if (rst || clr) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            dir_up   <= 1'b0;
            pend_vld <= 1'b0;
            pend_up  <= 1'b0;
            pos      <= '0;
            at_limit <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_vld) begin
                        if (!new_req) pend_vld <= 1'b0;
                        if (in_range) begin
                            state  <= ST_PULSE;
                            dir_up <= req_up;
                            pos    <= POS_W'(nxt);
                        end else begin
                            at_limit <= 1'b1;
                        end
                    end
                end
                ST_PULSE, ST_HOLD: begin
                    if (state == ST_PULSE) begin
                        // HOLD spans GAP-2 cycles so the next IDLE decision
                        // lands the following pulse exactly GAP cycles later.
                        cnt   <= CNT_W'(GAP - 2);
                        state <= (GAP > 2) ? ST_HOLD : ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) state <= ST_IDLE;
                    end
                    if (new_req) begin
                        if (!pend_vld) begin
                            pend_vld <= 1'b1;
                            pend_up  <= new_up;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A shift reset in the same cycle suppresses the slip command.
    assign adv_pulse = (state == ST_PULSE) &&  dir_up && !clr;
    assign dly_pulse = (state == ST_PULSE) && !dir_up && !clr;
    assign busy      = (state != ST_IDLE) || pend_vld;

endmodule

// File: rtl/dts_shift_ctrl.sv
// Per-antenna sample-shift controller: synchronises software request levels,
// detects rising edges and fans them out to the per-lane slip controllers.
module dts_shift_ctrl
    import dts_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF,
    parameter int POS_W   = 6,
    parameter int GAP     = 16
) (
    input  logic                     user_clk,
    input  logic                     rst,
    input  logic [N_LANES-1:0]       shift_advance,
    input  logic [N_LANES-1:0]       shift_delay,
    input  logic                     shift_rst,
    output logic [N_LANES-1:0]       lane_adv_pulse,
    output logic [N_LANES-1:0]       lane_dly_pulse,
    output logic                     lane_rst_pulse,
    output logic [N_LANES*POS_W-1:0] lane_pos,
    output logic [N_LANES-1:0]       at_limit,
    output logic [N_LANES-1:0]       overrun,
    output logic                     busy
);

    localparam int RW = 2*N_LANES + 1;

    logic [RW-1:0]      req_in, s1, s2, s3, edge_q;
    logic [1:0]         arm_cnt;
    logic [N_LANES-1:0] lane_busy;

    assign req_in = {shift_rst, shift_delay, shift_advance};

    // Edges are masked until the edge flop has tracked the inputs once after
    // reset, so a level already high at reset release is not seen as an edge.
    always_ff @(posedge user_clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            edge_q  <= '0;
            arm_cnt <= '0;
        end else begin
            s1      <= req_in;
            s2      <= s1;
            s3      <= s2;
            edge_q  <= (arm_cnt == 2'd3) ? (s2 & ~s3) : '0;
            if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
        end
    end

    assign lane_rst_pulse = edge_q[RW-1];

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        dts_shift_lane #(
            .POS_W (POS_W),
            .GAP   (GAP)
        ) u_lane (
            .user_clk  (user_clk),
            .rst       (rst),
            .clr       (edge_q[RW-1]),
            .adv_edge  (edge_q[i]),
            .dly_edge  (edge_q[N_LANES+i]),
            .adv_pulse (lane_adv_pulse[i]),
            .dly_pulse (lane_dly_pulse[i]),
            .pos       (lane_pos[i*POS_W +: POS_W]),
            .at_limit  (at_limit[i]),
            .overrun   (overrun[i]),
            .busy      (lane_busy[i])
        );
    end

    assign busy = |lane_busy;

endmodule

// File: tb/tb_dts_shift_ctrl.sv
// Directed bench for dts_shift_ctrl: table of single-lane slips plus sequences
// for pending/overrun, saturation, shift reset and synchronous reset.
module tb_dts_shift_ctrl;

    localparam int NL = 12;
    localparam int PW = 6;
    localparam int GP = 16;

    logic               user_clk = 1'b0;
    logic               rst = 1'b1;
    logic [NL-1:0]      shift_advance = '0;
    logic [NL-1:0]      shift_delay = '0;
    logic               shift_rst = 1'b0;
    logic [NL-1:0]      lane_adv_pulse, lane_dly_pulse;
    logic               lane_rst_pulse;
    logic [NL*PW-1:0]   lane_pos;
    logic [NL-1:0]      at_limit, overrun;
    logic               busy;

    dts_shift_ctrl #(.N_LANES(NL), .POS_W(PW), .GAP(GP)) dut (
        .user_clk       (user_clk),
        .rst            (rst),
        .shift_advance  (shift_advance),
        .shift_delay    (shift_delay),
        .shift_rst      (shift_rst),
        .lane_adv_pulse (lane_adv_pulse),
        .lane_dly_pulse (lane_dly_pulse),
        .lane_rst_pulse (lane_rst_pulse),
        .lane_pos       (lane_pos),
        .at_limit       (at_limit),
        .overrun        (overrun),
        .busy           (busy)
    );

    always #5 user_clk = ~user_clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int adv_cnt[NL] = '{default: 0};
    int dly_cnt[NL] = '{default: 0};
    int rst_cnt = 0;
    int dly0_t[$];

    always @(posedge user_clk) cyc <= cyc + 1;

    always @(negedge user_clk) begin
        for (int l = 0; l < NL; l++) begin
            if (lane_adv_pulse[l]) adv_cnt[l]++;
            if (lane_dly_pulse[l]) dly_cnt[l]++;
        end
        if (lane_dly_pulse[0]) dly0_t.push_back(cyc);
        if (lane_rst_pulse) rst_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge user_clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pos_of(input int l);
        logic signed [PW-1:0] p;
        p = lane_pos[l*PW +: PW];
        return int'(p);
    endfunction

    int model[NL] = '{default: 0};

    function automatic int pos_mism();
        int m = 0;
        for (int l = 0; l < NL; l++) if (pos_of(l) != model[l]) m++;
        return m;
    endfunction

    typedef struct {
        int   lane;
        logic adv;
        logic dly;
        logic exp_adv;
        logic exp_dly;
        int   exp_pos;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base, diff;

        vecs[0] = '{3, 1'b1, 1'b0, 1'b1, 1'b0,  1};
        vecs[1] = '{5, 1'b1, 1'b1, 1'b0, 1'b0,  0};
        vecs[2] = '{7, 1'b0, 1'b1, 1'b0, 1'b1, -1};
        vecs[3] = '{3, 1'b0, 1'b1, 1'b0, 1'b1,  0};
        vecs[4] = '{1, 1'b1, 1'b0, 1'b1, 1'b0,  1};
        vecs[5] = '{9, 1'b0, 1'b1, 1'b0, 1'b1, -1};

        // Reset state
        tick(3);
        chk("reset pos", pos_mism(), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset flags", int'(at_limit | overrun), 0);
        chk("reset pulses", int'({lane_adv_pulse, lane_dly_pulse, lane_rst_pulse}), 0);
        rst = 1'b0;
        tick(5);

        // Table of single requests from idle
        for (int k = 0; k < 6; k++) begin
            shift_advance[vecs[k].lane] = vecs[k].adv;
            shift_delay[vecs[k].lane]   = vecs[k].dly;
            tick(3);
            chk($sformatf("v%0d early pulse", k), int'(lane_adv_pulse | lane_dly_pulse), 0);
            tick(1);
            chk($sformatf("v%0d adv pulse", k), int'(lane_adv_pulse),
                vecs[k].exp_adv ? (1 << vecs[k].lane) : 0);
            chk($sformatf("v%0d dly pulse", k), int'(lane_dly_pulse),
                vecs[k].exp_dly ? (1 << vecs[k].lane) : 0);
            model[vecs[k].lane] = vecs[k].exp_pos;
            chk($sformatf("v%0d pos lane", k), pos_of(vecs[k].lane), vecs[k].exp_pos);
            chk($sformatf("v%0d pos all", k), pos_mism(), 0);
            tick(1);
            chk($sformatf("v%0d pulse width", k), int'(lane_adv_pulse | lane_dly_pulse), 0);
            shift_advance = '0;
            shift_delay   = '0;
            tick(20);
            chk($sformatf("v%0d idle busy", k), int'(busy), 0);
            chk($sformatf("v%0d flags", k), int'(at_limit | overrun), 0);
        end

        // Pending slot and overrun on lane 0
        base = dly_cnt[0];
        dly0_t.delete();
        for (int r = 0; r < 3; r++) begin
            shift_delay[0] = 1'b1;
            tick(1);
            shift_delay[0] = 1'b0;
            tick(1);
        end
        tick(40);
        chk("pend pulses", dly_cnt[0] - base, 2);
        diff = (dly0_t.size() >= 2) ? dly0_t[1] - dly0_t[0] : -1;
        chk("pend spacing", diff, GP);
        model[0] = -2;
        chk("pend pos", pos_of(0), -2);
        chk("pend overrun", int'(overrun), 1);
        chk("pend at_limit", int'(at_limit), 0);

        // Saturation on lane 11
        base = adv_cnt[11];
        for (int r = 0; r < 33; r++) begin
            shift_advance[11] = 1'b1;
            tick(1);
            shift_advance[11] = 1'b0;
            tick(19);
        end
        chk("sat pulses", adv_cnt[11] - base, 31);
        chk("sat pos", pos_of(11), 31);
        chk("sat at_limit", int'(at_limit[11]), 1);
        chk("sat overrun", int'(overrun[11]), 0);
        base = dly_cnt[11];
        shift_delay[11] = 1'b1;
        tick(1);
        shift_delay[11] = 1'b0;
        tick(20);
        chk("sat delay pulse", dly_cnt[11] - base, 1);
        chk("sat delay pos", pos_of(11), 30);

        // Shift reset with a simultaneous advance on lane 4
        base = rst_cnt;
        diff = adv_cnt[4];
        shift_rst        = 1'b1;
        shift_advance[4] = 1'b1;
        tick(2);
        chk("srst early", int'(lane_rst_pulse), 0);
        tick(1);
        chk("srst pulse", int'(lane_rst_pulse), 1);
        tick(1);
        chk("srst width", int'(lane_rst_pulse), 0);
        for (int l = 0; l < NL; l++) model[l] = 0;
        chk("srst pos", pos_mism(), 0);
        chk("srst flags", int'(at_limit | overrun), 0);
        chk("srst busy", int'(busy), 0);
        tick(10);
        chk("srst pulse count", rst_cnt - base, 1);
        chk("srst adv discarded", adv_cnt[4] - diff, 0);
        chk("srst lane4 pos", pos_of(4), 0);
        shift_rst        = 1'b0;
        shift_advance[4] = 1'b0;
        tick(5);

        // Synchronous reset during lane 2 HOLD with advance held high
        shift_advance[2] = 1'b1;
        tick(4);
        chk("rst pre pulse", int'(lane_adv_pulse[2]), 1);
        chk("rst pre pos", pos_of(2), 1);
        tick(3);
        chk("rst pre busy", int'(busy), 1);
        rst = 1'b1;
        tick(1);
        chk("rst pos", pos_mism(), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst outputs", int'({lane_adv_pulse, lane_dly_pulse, lane_rst_pulse, at_limit, overrun}), 0);
        base = adv_cnt[2];
        tick(2);
        rst = 1'b0;
        tick(30);
        chk("rst no pulse", adv_cnt[2] - base, 0);
        chk("rst post pos", pos_of(2), 0);
        chk("rst post busy", int'(busy), 0);
        shift_advance[2] = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
